// File: rtl/eth_mac_status_pkg.sv
// Shared definitions for the Ethernet MAC status counter block: event index map,
// error classification and CSR address constants.
package eth_mac_status_pkg;

  localparam int NUM_STATUS_EVENTS = 9;

  typedef enum logic [3:0] {
    EV_TX_ERROR_UNDERFLOW = 4'd0,
    EV_TX_FIFO_OVERFLOW   = 4'd1,
    EV_TX_FIFO_BAD_FRAME  = 4'd2,
    EV_TX_FIFO_GOOD_FRAME = 4'd3,
    EV_RX_ERROR_BAD_FRAME = 4'd4,
    EV_RX_ERROR_BAD_FCS   = 4'd5,
    EV_RX_FIFO_OVERFLOW   = 4'd6,
    EV_RX_FIFO_BAD_FRAME  = 4'd7,
    EV_RX_FIFO_GOOD_FRAME = 4'd8
  } status_event_t;

  // Good-frame events (3 and 8) are statistics only and never flag an error.
  localparam logic [NUM_STATUS_EVENTS-1:0] ERROR_EVENT_MASK = 9'b0_1111_0111;

  localparam logic [3:0] STICKY_ADDR = 4'd9;

endpackage

// File: rtl/eth_mac_status_if.sv
// Nine single-cycle status strobes emitted by the Ethernet MAC and its FIFOs.
interface eth_mac_status_interface;

  logic tx_error_underflow;
  logic tx_fifo_overflow;
  logic tx_fifo_bad_frame;
  logic tx_fifo_good_frame;
  logic rx_error_bad_frame;
  logic rx_error_bad_fcs;
  logic rx_fifo_overflow;
  logic rx_fifo_bad_frame;
  logic rx_fifo_good_frame;

  modport master (
    output tx_error_underflow, tx_fifo_overflow, tx_fifo_bad_frame, tx_fifo_good_frame,
    output rx_error_bad_frame, rx_error_bad_fcs, rx_fifo_overflow, rx_fifo_bad_frame,
    output rx_fifo_good_frame
  );

  modport slave (
    input tx_error_underflow, tx_fifo_overflow, tx_fifo_bad_frame, tx_fifo_good_frame,
    input rx_error_bad_frame, rx_error_bad_fcs, rx_fifo_overflow, rx_fifo_bad_frame,
    input rx_fifo_good_frame
  );

endinterface

// File: rtl/eth_mac_status_counter.sv
// Single event counter with hard clear, read-clear (keeps a coincident event)
// and selectable saturate/wrap arithmetic.
module eth_mac_status_counter #(
  parameter int COUNT_WIDTH = 32,
  parameter int SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clr,
  input  logic                   rd_clr,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] v);
    if ((SATURATE != 0) && (&v)) return v;
    return v + ONE;
  endfunction

  // clr drops a coincident event; rd_clr restarts from that event instead.
  always_ff @(posedge clk) begin
    if (rst || clr)  count <= '0;
    else if (rd_clr) count <= inc ? ONE : '0;
    else if (inc)    count <= bump(count);
  end

endmodule

// File: rtl/eth_mac_status_counters.sv
// MAC status event counters with sticky error mask, maskable interrupt and a
// registered read port. Define ETH_MAC_STATUS_CLEAR_ON_READ_EN for clear-on-read.
module eth_mac_status_counters
  import eth_mac_status_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int SATURATE    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  eth_mac_status_interface.slave       status,
  input  logic                         clear,
  input  logic [NUM_STATUS_EVENTS-1:0] irq_mask,
  input  logic                         rd_en,
  input  logic [3:0]                   rd_addr,
  output logic                         rd_valid,
  output logic [COUNT_WIDTH-1:0]       rd_data,
  output logic                         error_irq
);

  localparam int N = NUM_STATUS_EVENTS;

  logic [N-1:0]                  events;
  logic [N-1:0][COUNT_WIDTH-1:0] counts;
  logic [N-1:0]                  rd_clr_vec;
  logic                          sticky_rd_clr;
  logic [N-1:0]                  sticky;
  logic [N-1:0]                  sticky_next;
  logic [COUNT_WIDTH-1:0]        rd_sel_p0;

  assign events = {status.rx_fifo_good_frame, status.rx_fifo_bad_frame,
                   status.rx_fifo_overflow,   status.rx_error_bad_fcs,
                   status.rx_error_bad_frame, status.tx_fifo_good_frame,
                   status.tx_fifo_bad_frame,  status.tx_fifo_overflow,
                   status.tx_error_underflow};

`ifdef ETH_MAC_STATUS_CLEAR_ON_READ_EN
  always_comb begin
    rd_clr_vec = '0;
    for (int i = 0; i < N; i++) rd_clr_vec[i] = rd_en && (rd_addr == 4'(i));
  end
  assign sticky_rd_clr = rd_en && (rd_addr == STICKY_ADDR);
`else
  assign rd_clr_vec    = '0;
  assign sticky_rd_clr = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_cnt
    eth_mac_status_counter #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .SATURATE    (SATURATE)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (events[i]),
      .clr    (clear),
      .rd_clr (rd_clr_vec[i]),
      .count  (counts[i])
    );
  end

  always_comb begin
    sticky_next = sticky;
    if (clear)              sticky_next = '0;
    else if (sticky_rd_clr) sticky_next = events & ERROR_EVENT_MASK;
    else                    sticky_next = sticky | (events & ERROR_EVENT_MASK);
  end

  // Interrupt looks at sticky_next so it rises the cycle right after the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky    <= '0;
      error_irq <= 1'b0;
    end else begin
      sticky    <= sticky_next;
      error_irq <= |(sticky_next & irq_mask);
    end
  end

  always_comb begin
    rd_sel_p0 = '0;
    for (int i = 0; i < N; i++) if (rd_addr == 4'(i)) rd_sel_p0 = counts[i];
    if (rd_addr == STICKY_ADDR) rd_sel_p0 = COUNT_WIDTH'(sticky);
  end

  // Read stage: capture pre-update state; data holds while no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_sel_p0;
    end
  end

endmodule

// File: tb/tb_eth_mac_status_counters.sv
// Directed bench for eth_mac_status_counters: one shared status stream drives a
// 32-bit saturating instance plus 9-bit saturating and 9-bit wrapping instances.
module tb_eth_mac_status_counters;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [8:0] irq_mask;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic        rd_valid,   rd_valid_s,   rd_valid_w;
  logic [31:0] rd_data;
  logic [8:0]  rd_data_s,  rd_data_w;
  logic        error_irq,  error_irq_s,  error_irq_w;

  int checks = 0;
  int errors = 0;

  eth_mac_status_interface st ();

  always #5 clk = ~clk;

  eth_mac_status_counters #(.COUNT_WIDTH(32), .SATURATE(1)) u_dut (
    .clk(clk), .rst(rst), .status(st), .clear(clear), .irq_mask(irq_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .error_irq(error_irq)
  );

  eth_mac_status_counters #(.COUNT_WIDTH(9), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .status(st), .clear(clear), .irq_mask(irq_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_s), .rd_data(rd_data_s),
    .error_irq(error_irq_s)
  );

  eth_mac_status_counters #(.COUNT_WIDTH(9), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .status(st), .clear(clear), .irq_mask(irq_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_w), .rd_data(rd_data_w),
    .error_irq(error_irq_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strobes(input logic [8:0] v);
    st.tx_error_underflow = v[0];
    st.tx_fifo_overflow   = v[1];
    st.tx_fifo_bad_frame  = v[2];
    st.tx_fifo_good_frame = v[3];
    st.rx_error_bad_frame = v[4];
    st.rx_error_bad_fcs   = v[5];
    st.rx_fifo_overflow   = v[6];
    st.rx_fifo_bad_frame  = v[7];
    st.rx_fifo_good_frame = v[8];
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset with every input active: rst must win.
    rst = 1'b1; clear = 1'b0; irq_mask = 9'h1FF; rd_en = 1'b1; rd_addr = 4'd0;
    set_strobes(9'h1FF);
    repeat (3) tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_error_irq", error_irq, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0; rd_en = 1'b0; irq_mask = 9'h000;
    set_strobes(9'h000);
    do_read(4'd0);
    check("first_read_valid", rd_valid, 1);
    check("first_read_data", rd_data, 0);

    // All nine strobes for five cycles.
    set_strobes(9'h1FF);
    repeat (5) tick();
    set_strobes(9'h000);
    for (int i = 0; i < 9; i++) begin
      do_read(4'(i));
      check($sformatf("all5_cnt%0d", i), rd_data, 5);
    end
    do_read(4'd9);
    check("all5_sticky", rd_data, 32'h0F7);
    rd_addr = 4'd0;
    tick();
    check("idle_rd_valid", rd_valid, 0);
    check("idle_rd_data_hold", rd_data, 32'h0F7);
    do_read(4'd12);
    check("addr12_zero", rd_data, 0);
    check("irq_masked_off", error_irq, 0);

    // Interrupt behaviour with only bad_fcs enabled.
    irq_mask = 9'h020;
    pulse_clear();
    check("irq_after_clear", error_irq, 0);
    do_read(4'd9);
    check("sticky_after_clear", rd_data, 0);
    do_read(4'd0);
    check("cnt0_after_clear", rd_data, 0);
    set_strobes(9'h020);
    tick();
    set_strobes(9'h000);
    check("irq_rise", error_irq, 1);
    tick();
    check("irq_sticky_hold", error_irq, 1);
    irq_mask = 9'h000;
    tick();
    check("irq_mask_drop", error_irq, 0);
    irq_mask = 9'h020;
    tick();
    check("irq_mask_restore", error_irq, 1);
    pulse_clear();
    check("irq_clear_drop", error_irq, 0);
    set_strobes(9'h004);
    tick();
    set_strobes(9'h000);
    check("irq_unmasked_event", error_irq, 0);
    tick();
    check("irq_unmasked_event2", error_irq, 0);
    do_read(4'd9);
    check("sticky_bad_frame", rd_data, 32'h004);

    // Clear colliding with an event and a read.
    pulse_clear();
    set_strobes(9'h002);
    repeat (4) tick();
    clear = 1'b1; rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    clear = 1'b0; rd_en = 1'b0;
    set_strobes(9'h000);
    check("collide_rd_valid", rd_valid, 1);
    check("collide_rd_data", rd_data, 4);
    do_read(4'd1);
    check("collide_cnt1", rd_data, 0);
    do_read(4'd9);
    check("collide_sticky", rd_data, 0);

    // Saturate vs wrap on the 9-bit instances.
    pulse_clear();
    set_strobes(9'h100);
    repeat (600) tick();
    set_strobes(9'h000);
    do_read(4'd8);
    check("good600_w32", rd_data, 600);
    check("good600_sat9", rd_data_s, 511);
    check("good600_wrap9", rd_data_w, 88);
    check("good600_valid9", rd_valid_s & rd_valid_w, 1);
    do_read(4'd9);
    check("good_no_sticky", rd_data, 0);

    // Read coinciding with an event on the same counter.
    pulse_clear();
    set_strobes(9'h020);
    repeat (7) tick();
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    set_strobes(9'h000);
    check("fcs_read_pre", rd_data, 7);
    do_read(4'd5);
`ifdef ETH_MAC_STATUS_CLEAR_ON_READ_EN
    check("fcs_read_next", rd_data, 1);
`else
    check("fcs_read_next", rd_data, 8);
`endif
    check("fcs_irq", error_irq, 1);
    do_read(4'd9);
    check("sticky_read1", rd_data, 32'h020);
    do_read(4'd9);
`ifdef ETH_MAC_STATUS_CLEAR_ON_READ_EN
    check("sticky_read2", rd_data, 0);
`else
    check("sticky_read2", rd_data, 32'h020);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
